// File: rtl/syntacore_slave_resp.sv
// Slave-side responder for the crossbar req/ack bus: one-cycle ack after WAIT_CYC
// wait states, backed by a local word memory, with completed-transaction counters.
module syntacore_slave_resp #(
  parameter int DATA_WDTH = 32,
  parameter int ADDR_WDTH = 32,
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_CYC  = 2,
  parameter int CNT_WDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_WDTH-1:0] i_addr,
  input  logic                 i_cmd,
  input  logic [DATA_WDTH-1:0] i_wdata,
  output logic                 o_ack,
  output logic [DATA_WDTH-1:0] o_rdata,
  output logic [CNT_WDTH-1:0]  o_wr_cnt,
  output logic [CNT_WDTH-1:0]  o_rd_cnt,
  output logic                 o_busy,
  output logic [1:0]           o_state
);

  // Handshake: i_req rises with addr/cmd/wdata and is held until o_ack; dropping it
  // while waiting aborts the transaction, once in ACK the response is committed.

  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           wait_cnt, wait_cnt_nxt;
  logic                 capture;
  logic [IDX_W-1:0]     cap_idx;
  logic                 cap_cmd;
  logic [DATA_WDTH-1:0] cap_wdata;
  logic [DATA_WDTH-1:0] mem [MEM_DEPTH];
  logic                 addr_unused;

  assign addr_unused = ^i_addr[ADDR_WDTH-1:IDX_W];

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req) begin
          capture      = 1'b1;
          wait_cnt_nxt = WAIT_INIT;
          state_nxt    = (WAIT_CYC == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_req) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt <= 8'd1) begin
          wait_cnt_nxt = 8'd0;
          state_nxt    = ST_ACK;
        end else begin
          wait_cnt_nxt = wait_cnt - 8'd1;
        end
      end
      ST_ACK:  state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
      o_wr_cnt <= '0;
      o_rd_cnt <= '0;
      o_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == ST_ACK) begin
        if (cap_cmd) o_wr_cnt <= o_wr_cnt + 1'b1;
        else         o_rd_cnt <= o_rd_cnt + 1'b1;
      end
      // Read data lives for exactly the RESP cycle; zero otherwise.
      o_rdata <= (state == ST_ACK && !cap_cmd) ? mem[cap_idx] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (capture) begin
      cap_idx   <= i_addr[IDX_W-1:0];
      cap_cmd   <= i_cmd;
      cap_wdata <= i_wdata;
    end
  end

  // A write whose commit edge coincides with reset is still kept.
  always_ff @(posedge i_clk) begin
    if (state == ST_ACK && cap_cmd) mem[cap_idx] <= cap_wdata;
  end

  assign o_ack   = (state == ST_ACK);
  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

endmodule
